// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction store loaded from a byte stream, then one-word-per-clock fetch register.
// Optional FETCH_PARITY_EN adds a stored even-parity bit per word and a parity_err output.
module instr_fetch #(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic                  hold,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  run,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [6:0]            instr_src,
    output logic [6:0]            instr_dest
`ifdef FETCH_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef FETCH_PARITY_EN
    localparam int SW = INSTR_WIDTH + 1;
`else
    localparam int SW = INSTR_WIDTH;
`endif

    typedef enum logic [1:0] {LD_LO, LD_HI, RUN} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   wcnt, wcnt_nx;
    logic [7:0]              lo_byte;
    logic                    xfer;
    logic                    we;
    logic [INSTR_WIDTH-1:0]  wdata;
    logic [SW-1:0]           store_word;
    logic [SW-1:0]           rd_word;
    logic [SW-1:0]           mem [DEPTH];

    assign ld_ready = (state != RUN);
    assign run      = (state == RUN);
    // Gating with rst_n keeps a loader byte presented during reset out of the store.
    assign xfer     = ld_valid & ld_ready & rst_n;

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        we       = 1'b0;
        wdata    = '0;
        case (state)
            LD_LO: begin
                if (xfer) begin
                    if (ld_last) begin
                        we       = 1'b1;
                        wdata    = {{(INSTR_WIDTH-8){1'b0}}, ld_data};
                        state_nx = RUN;
                    end else begin
                        state_nx = LD_HI;
                    end
                end
            end
            LD_HI: begin
                if (xfer) begin
                    we      = 1'b1;
                    wdata   = {ld_data[INSTR_WIDTH-9:0], lo_byte};
                    wcnt_nx = wcnt + 1'b1;
                    if (ld_last || (&wcnt))
                        state_nx = RUN;
                    else
                        state_nx = LD_LO;
                end
            end
            RUN:     state_nx = RUN;
            default: state_nx = LD_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LD_LO;
            wcnt    <= '0;
            lo_byte <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (state == LD_LO && xfer)
                lo_byte <= ld_data;
        end
    end

`ifdef FETCH_PARITY_EN
    assign store_word = {^wdata, wdata};
`else
    assign store_word = wdata;
`endif

    // Store is intentionally not reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[wcnt] <= store_word;
    end

    assign rd_word = mem[pc_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            instr_src   <= '0;
            instr_dest  <= '0;
`ifdef FETCH_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else if (state == RUN && !hold) begin
            instr_valid <= 1'b1;
            instr_pc    <= pc_addr;
            instr_src   <= rd_word[INSTR_WIDTH-1:INSTR_WIDTH-7];
            instr_dest  <= rd_word[6:0];
`ifdef FETCH_PARITY_EN
            parity_err  <= ^rd_word;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] pc_addr = '0;
    logic       hold = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_last = 1'b0;
    logic       ld_ready;
    logic       run;
    logic       instr_valid;
    logic [5:0] instr_pc;
    logic [6:0] instr_src;
    logic [6:0] instr_dest;
`ifdef FETCH_PARITY_EN
    logic       parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_WIDTH(6), .INSTR_WIDTH(14)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_addr     (pc_addr),
        .hold        (hold),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .run         (run),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .instr_src   (instr_src),
        .instr_dest  (instr_dest)
`ifdef FETCH_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
        check({tag, "_run"},      32'(run),      32'd0);
        check({tag, "_fetch"},    {11'd0, instr_valid, instr_pc, instr_src, instr_dest}, 32'd0);
    endtask

    // fetch word at a; expected word supplied by the caller
    task automatic fetch_check(input string tag, input logic [5:0] a, input logic [13:0] w);
        pc_addr = a;
        tick();
        check(tag, {11'd0, instr_valid, instr_pc, instr_src, instr_dest}, {11'd0, 1'b1, a, w});
    endtask

    function automatic logic [7:0] big_lo(input int i);
        return 8'(i * 4 + 1);
    endfunction

    function automatic logic [7:0] big_hi(input int i);
        return 8'hC0 | 8'(i);
    endfunction

    function automatic logic [13:0] big_word(input int i);
        logic [7:0] h;
        h = big_hi(i);
        return {h[5:0], big_lo(i)};
    endfunction

    initial begin
        // reset state
        tick();
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;

        // two-byte program word 0 = 14'h1021
        send_byte(8'h21, 1'b0);
        check("lo_ready", 32'(ld_ready), 32'd1);
        send_byte(8'h10, 1'b1);
        check("t1_run",      32'(run),      32'd1);
        check("t1_ld_ready", 32'(ld_ready), 32'd0);
        check("t1_valid_pre", 32'(instr_valid), 32'd0);
        pc_addr = 6'd0;
        tick();
        check("t1_src",   32'(instr_src),   32'h20);
        check("t1_dest",  32'(instr_dest),  32'h21);
        check("t1_pc",    32'(instr_pc),    32'd0);
        check("t1_valid", 32'(instr_valid), 32'd1);

        // full 64-word load without ld_last
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send_byte(big_lo(i), 1'b0);
            if (i < 63)
                send_byte(big_hi(i), 1'b0);
        end
        check("t2_run_before_last", 32'(run), 32'd0);
        send_byte(big_hi(63), 1'b0);
        check("t2_run",      32'(run),      32'd1);
        check("t2_ld_ready", 32'(ld_ready), 32'd0);
        for (int i = 0; i < 4; i++)
            send_byte(8'hFF, 1'b1);
        check("t2_run_extra", 32'(run), 32'd1);
        for (int i = 0; i < 64; i++)
            fetch_check($sformatf("t2_word%0d", i), 6'(i), big_word(i));

        // hold freezes the fetch register
        fetch_check("t3_word5", 6'd5, big_word(5));
        hold = 1'b1;
        pc_addr = 6'd6;
        tick();
        check("t3_hold1", {11'd0, instr_valid, instr_pc, instr_src, instr_dest}, {11'd0, 1'b1, 6'd5, big_word(5)});
        pc_addr = 6'd7;
        tick();
        tick();
        check("t3_hold3", {11'd0, instr_valid, instr_pc, instr_src, instr_dest}, {11'd0, 1'b1, 6'd5, big_word(5)});
        hold = 1'b0;
        tick();
        check("t3_release", {11'd0, instr_valid, instr_pc, instr_src, instr_dest}, {11'd0, 1'b1, 6'd7, big_word(7)});

        // ld_last on the very first byte
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send_byte(8'h7F, 1'b1);
        check("t4_run", 32'(run), 32'd1);
        fetch_check("t4_word0", 6'd0, 14'h007F);

        // asynchronous reset from RUN, then mid-load
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("t5_async");
        tick();
        rst_n = 1'b1;
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 8'h99;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_midload");
        ld_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        send_byte(8'h56, 1'b0);
        send_byte(8'h2B, 1'b1);
        check("t5_run", 32'(run), 32'd1);
        fetch_check("t5_reload", 6'd0, 14'h2B56);

`ifdef FETCH_PARITY_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("par_reset", 32'(parity_err), 32'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b1);
        force dut.mem[0][0] = 1'b0;
        pc_addr = 6'd0;
        tick();
        check("par_err", 32'(parity_err), 32'd1);
        release dut.mem[0][0];
        pc_addr = 6'd1;
        tick();
        check("par_clean", 32'(parity_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
